// File: rtl/tcdm_lrsc_queue.sv
// tcdm_lrsc_queue: multi-entry LR/SC reservation unit in front of one TCDM bank, with in-order responses.
// Optional SC success/failure counters are enabled by defining TCDM_LRSC_PERF_EN.
`default_nettype none

module tcdm_lrsc_queue #(
  parameter int unsigned NumEntries = 1,
  parameter int unsigned AddrWidth  = 8,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned IdWidth    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [AddrWidth-1:0]   in_addr_i,
  input  logic                   in_wen_i,
  input  logic [3:0]             in_amo_i,
  input  logic [IdWidth-1:0]     in_id_i,
  input  logic [DataWidth-1:0]   in_wdata_i,
  input  logic [DataWidth/8-1:0] in_be_i,
  output logic                   bank_req_o,
  output logic [AddrWidth-1:0]   bank_addr_o,
  output logic                   bank_wen_o,
  output logic [DataWidth-1:0]   bank_wdata_o,
  output logic [DataWidth/8-1:0] bank_be_o,
  input  logic [DataWidth-1:0]   bank_rdata_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [DataWidth-1:0]   resp_data_o,
  output logic [IdWidth-1:0]     resp_id_o
`ifdef TCDM_LRSC_PERF_EN
  ,
  output logic [15:0]            sc_ok_cnt_o,
  output logic [15:0]            sc_fail_cnt_o
`endif
);

  localparam int unsigned IdxWidth = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumEntries - 1);
  localparam logic [3:0] AmoLr = 4'hA;
  localparam logic [3:0] AmoSc = 4'hB;

  logic accept;
  logic is_lr;
  logic is_sc;
  logic is_write;
  logic sc_match;
  logic sc_fail;

  logic [NumEntries-1:0] res_valid;
  logic [NumEntries-1:0] res_valid_d;
  logic [NumEntries-1:0] id_hit;
  logic [NumEntries-1:0] addr_hit;
  logic [IdWidth-1:0]    res_id   [NumEntries];
  logic [AddrWidth-1:0]  res_addr [NumEntries];
  logic [IdxWidth-1:0]   rr;
  logic [IdxWidth-1:0]   id_idx;
  logic [IdxWidth-1:0]   free_idx;
  logic [IdxWidth-1:0]   lr_slot;
  logic                  has_free;
  logic                  lr_evict;

  logic                  inflight;
  logic                  fl_read;
  logic                  fl_fail;
  logic [IdWidth-1:0]    fl_id;
  logic [DataWidth-1:0]  fl_data;

  logic [1:0]            stored;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DataWidth-1:0]  buf_data [2];
  logic [IdWidth-1:0]    buf_id   [2];
  logic                  buf_empty;
  logic                  buf_push;
  logic                  buf_pop;

  // Credits count the in-flight slot and stored entries, both registered,
  // so a pop frees credit only from the following cycle.
  assign in_ready_o = !rst_i && (({1'b0, inflight} + stored) < 2'd2);
  assign accept     = in_valid_i && in_ready_o;

  assign is_lr    = (in_amo_i == AmoLr);
  assign is_sc    = (in_amo_i == AmoSc);
  assign is_write = is_sc || (!is_lr && in_wen_i);

  always_comb begin
    id_hit   = '0;
    addr_hit = '0;
    id_idx   = '0;
    free_idx = '0;
    has_free = 1'b0;
    // Descending scan so the lowest matching / free index wins.
    for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
      id_hit[i]   = res_valid[i] && (res_id[i] == in_id_i);
      addr_hit[i] = res_valid[i] && (res_addr[i] == in_addr_i);
      if (id_hit[i]) begin
        id_idx = IdxWidth'(i);
      end
      if (!res_valid[i]) begin
        free_idx = IdxWidth'(i);
        has_free = 1'b1;
      end
    end
  end

  assign sc_match = |(id_hit & addr_hit);
  assign sc_fail  = is_sc && !sc_match;
  assign lr_evict = !(|id_hit) && !has_free;
  assign lr_slot  = (|id_hit) ? id_idx : (has_free ? free_idx : rr);

  always_comb begin
    res_valid_d = res_valid;
    if (accept) begin
      if (is_lr) begin
        for (int i = 0; i < int'(NumEntries); i++) begin
          if (lr_slot == IdxWidth'(i)) begin
            res_valid_d[i] = 1'b1;
          end
        end
      end else if (sc_fail) begin
        res_valid_d = res_valid & ~id_hit;
      end else if (is_write) begin
        res_valid_d = res_valid & ~addr_hit;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid <= '0;
      rr        <= '0;
      for (int i = 0; i < int'(NumEntries); i++) begin
        res_id[i]   <= '0;
        res_addr[i] <= '0;
      end
    end else begin
      res_valid <= res_valid_d;
      if (accept && is_lr && lr_evict) begin
        rr <= (rr == LastIdx) ? '0 : rr + IdxWidth'(1);
      end
      for (int i = 0; i < int'(NumEntries); i++) begin
        if (accept && is_lr && (lr_slot == IdxWidth'(i))) begin
          res_id[i]   <= in_id_i;
          res_addr[i] <= in_addr_i;
        end
      end
    end
  end

  // A failing SC never reaches the bank.
  assign bank_req_o   = accept && !sc_fail;
  assign bank_wen_o   = bank_req_o && is_write;
  assign bank_addr_o  = in_addr_i;
  assign bank_wdata_o = in_wdata_i;
  assign bank_be_o    = in_be_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight <= 1'b0;
      fl_read  <= 1'b0;
      fl_fail  <= 1'b0;
      fl_id    <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        fl_id   <= in_id_i;
        fl_read <= !is_write;
        fl_fail <= sc_fail;
      end
    end
  end

  assign fl_data = fl_read ? bank_rdata_i : {{(DataWidth-1){1'b0}}, fl_fail};

  assign buf_empty    = (stored == 2'd0);
  assign resp_valid_o = !buf_empty || inflight;
  assign buf_pop      = !buf_empty && resp_ready_i;
  // The in-flight result bypasses storage only when it is consumed directly.
  assign buf_push     = inflight && !(buf_empty && resp_ready_i);

  always_comb begin
    resp_data_o = '0;
    resp_id_o   = '0;
    if (!buf_empty) begin
      resp_data_o = buf_data[rd_ptr];
      resp_id_o   = buf_id[rd_ptr];
    end else if (inflight) begin
      resp_data_o = fl_data;
      resp_id_o   = fl_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stored      <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_id[0]   <= '0;
      buf_id[1]   <= '0;
    end else begin
      if (buf_push) begin
        buf_data[wr_ptr] <= fl_data;
        buf_id[wr_ptr]   <= fl_id;
        wr_ptr           <= ~wr_ptr;
      end
      if (buf_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({buf_push, buf_pop})
        2'b10:   stored <= stored + 2'd1;
        2'b01:   stored <= stored - 2'd1;
        default: stored <= stored;
      endcase
    end
  end

`ifdef TCDM_LRSC_PERF_EN
  logic [15:0] sc_ok_cnt;
  logic [15:0] sc_fail_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sc_ok_cnt   <= '0;
      sc_fail_cnt <= '0;
    end else begin
      if (accept && is_sc && sc_match && (sc_ok_cnt != 16'hFFFF)) begin
        sc_ok_cnt <= sc_ok_cnt + 16'd1;
      end
      if (accept && sc_fail && (sc_fail_cnt != 16'hFFFF)) begin
        sc_fail_cnt <= sc_fail_cnt + 16'd1;
      end
    end
  end

  assign sc_ok_cnt_o   = sc_ok_cnt;
  assign sc_fail_cnt_o = sc_fail_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tcdm_lrsc_queue.sv
// tb_tcdm_lrsc_queue: scoreboard bench with a behavioural reservation/bank model.
`default_nettype none

module tb_tcdm_lrsc_queue;

  localparam int NE = 2;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_addr;
  logic        in_wen;
  logic [3:0]  in_amo;
  logic [7:0]  in_id;
  logic [31:0] in_wdata;
  logic [3:0]  in_be;
  logic        bank_req;
  logic [7:0]  bank_addr;
  logic        bank_wen;
  logic [31:0] bank_wdata;
  logic [3:0]  bank_be;
  logic [31:0] bank_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [7:0]  resp_id;
`ifdef TCDM_LRSC_PERF_EN
  logic [15:0] sc_ok_cnt;
  logic [15:0] sc_fail_cnt;
`endif

  tcdm_lrsc_queue #(
    .NumEntries(NE),
    .AddrWidth (8),
    .DataWidth (32),
    .IdWidth   (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_addr_i    (in_addr),
    .in_wen_i     (in_wen),
    .in_amo_i     (in_amo),
    .in_id_i      (in_id),
    .in_wdata_i   (in_wdata),
    .in_be_i      (in_be),
    .bank_req_o   (bank_req),
    .bank_addr_o  (bank_addr),
    .bank_wen_o   (bank_wen),
    .bank_wdata_o (bank_wdata),
    .bank_be_o    (bank_be),
    .bank_rdata_i (bank_rdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_id_o    (resp_id)
`ifdef TCDM_LRSC_PERF_EN
    ,
    .sc_ok_cnt_o  (sc_ok_cnt),
    .sc_fail_cnt_o(sc_fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'h0000DEAD : {a, ~a, a ^ 8'h5A, 8'h3C};
  endfunction

  // Bank memory: one-cycle read latency.
  logic [31:0] bank_mem [256];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) bank_mem[i] <= init_val(i[7:0]);
      mem_ready <= 1'b1;
    end else if (bank_req) begin
      if (bank_wen) begin
        for (int b = 0; b < 4; b++)
          if (bank_be[b]) bank_mem[bank_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
      end else begin
        bank_rdata <= bank_mem[bank_addr];
      end
    end
  end

  // Reference model state
  exp_t        exp_q[$];
  logic [31:0] resp_log[$];
  logic [31:0] model_mem [256];
  bit          model_ready = 1'b0;
  bit          res_v    [NE];
  logic [7:0]  res_id   [NE];
  logic [7:0]  res_addr [NE];
  int          rr = 0;
  logic [15:0] m_ok = '0;
  logic [15:0] m_fail = '0;

  task automatic model_accept();
    logic is_lr, is_sc, ok, wr;
    int   slot;
    exp_t e;
    is_lr = (in_amo == 4'hA);
    is_sc = (in_amo == 4'hB);
    ok = 1'b0;
    for (int j = 0; j < NE; j++)
      if (res_v[j] && res_id[j] == in_id && res_addr[j] == in_addr) ok = 1'b1;
    e.id = in_id;
    if (is_sc && !ok) begin
      chk("bank_req_scfail", bank_req, 1'b0);
      for (int j = 0; j < NE; j++)
        if (res_v[j] && res_id[j] == in_id) res_v[j] = 1'b0;
      e.data = 32'd1;
      if (m_fail != 16'hFFFF) m_fail++;
    end else begin
      wr = is_sc || (!is_lr && in_wen);
      chk("bank_req", bank_req, 1'b1);
      chk("bank_addr", bank_addr, in_addr);
      chk("bank_wen", bank_wen, wr);
      if (wr) begin
        chk("bank_wdata", bank_wdata, in_wdata);
        chk("bank_be", bank_be, in_be);
        for (int b = 0; b < 4; b++)
          if (in_be[b]) model_mem[in_addr][8*b +: 8] = in_wdata[8*b +: 8];
        for (int j = 0; j < NE; j++)
          if (res_v[j] && res_addr[j] == in_addr) res_v[j] = 1'b0;
        e.data = 32'd0;
        if (is_sc && m_ok != 16'hFFFF) m_ok++;
      end else begin
        e.data = model_mem[in_addr];
        if (is_lr) begin
          slot = -1;
          for (int j = 0; j < NE; j++)
            if (slot < 0 && res_v[j] && res_id[j] == in_id) slot = j;
          for (int j = 0; j < NE; j++)
            if (slot < 0 && !res_v[j]) slot = j;
          if (slot < 0) begin
            slot = rr;
            rr = (rr + 1) % NE;
          end
          res_v[slot]    = 1'b1;
          res_id[slot]   = in_id;
          res_addr[slot] = in_addr;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!model_ready) begin
      for (int i = 0; i < 256; i++) model_mem[i] = init_val(i[7:0]);
      model_ready = 1'b1;
    end
    if (rst) begin
      exp_q.delete();
      for (int j = 0; j < NE; j++) res_v[j] = 1'b0;
      rr = 0;
      m_ok = '0;
      m_fail = '0;
    end else begin
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("resp_valid", resp_valid, exp_q.size() > 0);
`ifdef TCDM_LRSC_PERF_EN
      chk("sc_ok_cnt", sc_ok_cnt, m_ok);
      chk("sc_fail_cnt", sc_fail_cnt, m_fail);
`endif
      if (resp_valid && exp_q.size() > 0) begin
        chk("resp_data", resp_data, exp_q[0].data);
        chk("resp_id", resp_id, exp_q[0].id);
        if (resp_ready) begin
          resp_log.push_back(resp_data);
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) model_accept();
      else chk("bank_req_idle", bank_req, 1'b0);
    end
  end

  task automatic send(input logic [3:0] amo, input logic wen, input logic [7:0] addr,
                      input logic [7:0] id, input logic [31:0] wdata, input logic [3:0] be);
    bit acc;
    in_valid = 1'b1;
    in_amo = amo; in_wen = wen; in_addr = addr; in_id = id; in_wdata = wdata; in_be = be;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) begin @(posedge clk); #1; end
    end
    chk("send_timeout", acc, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    resp_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wen = 1'b0; in_amo = '0;
    in_id = '0; in_wdata = '0; in_be = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", resp_id, 8'd0);
    chk("rst_bank_req", bank_req, 1'b0);
    @(posedge clk); #1;

    // LR then successful SC, then read back
    resp_log.delete();
    send(4'hA, 1'b0, 8'h10, 8'd3, 32'h0, 4'h0);
    send(4'hB, 1'b0, 8'h10, 8'd3, 32'h55, 4'hF);
    send(4'h0, 1'b0, 8'h10, 8'd9, 32'h0, 4'h0);
    drain();
    chk("lrsc_log_n", resp_log.size(), 3);
    chk("lr_data", resp_log[0], 32'h0000DEAD);
    chk("sc_ok_data", resp_log[1], 32'd0);
    chk("sc_wrote", resp_log[2], 32'h55);

    // Intervening write breaks the reservation
    resp_log.delete();
    send(4'hA, 1'b0, 8'h20, 8'd1, 32'h0, 4'h0);
    send(4'h0, 1'b1, 8'h20, 8'd2, 32'h77, 4'hF);
    send(4'hB, 1'b0, 8'h20, 8'd1, 32'h99, 4'hF);
    send(4'h0, 1'b0, 8'h20, 8'd1, 32'h0, 4'h0);
    drain();
    chk("brk_log_n", resp_log.size(), 4);
    chk("brk_sc_fail", resp_log[2], 32'd1);
    chk("brk_mem", resp_log[3], 32'h77);

    // Round-robin eviction with two entries
    pulse_reset();
    resp_log.delete();
    send(4'hA, 1'b0, 8'h50, 8'd1, 32'h0, 4'h0);
    send(4'hA, 1'b0, 8'h51, 8'd2, 32'h0, 4'h0);
    send(4'hA, 1'b0, 8'h52, 8'd3, 32'h0, 4'h0);
    send(4'hB, 1'b0, 8'h50, 8'd1, 32'hAA, 4'hF);
    send(4'hB, 1'b0, 8'h51, 8'd2, 32'hBB, 4'hF);
    drain();
    chk("evict_log_n", resp_log.size(), 5);
    chk("evict_sc1", resp_log[3], 32'd1);
    chk("evict_sc2", resp_log[4], 32'd0);

    // Backpressure: two credits, pop frees credit one cycle later
    resp_log.delete();
    resp_ready = 1'b0;
    in_valid = 1'b1; in_amo = 4'h0; in_wen = 1'b0; in_addr = 8'h40; in_id = 8'd5;
    @(negedge clk); chk("bp_rdy1", in_ready, 1'b1); @(posedge clk); #1;
    in_addr = 8'h41; in_id = 8'd6;
    @(negedge clk); chk("bp_rdy2", in_ready, 1'b1); @(posedge clk); #1;
    in_addr = 8'h42; in_id = 8'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("bp_full", in_ready, 1'b0); @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk); chk("bp_pop_cycle", in_ready, 1'b0); @(posedge clk); #1;
    @(negedge clk); chk("bp_after_pop", in_ready, 1'b1); @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("bp_log_n", resp_log.size(), 3);
    chk("bp_r0", resp_log[0], init_val(8'h40));
    chk("bp_r1", resp_log[1], init_val(8'h41));
    chk("bp_r2", resp_log[2], init_val(8'h42));

    // Reset with a pending response
    resp_ready = 1'b0;
    send(4'hA, 1'b0, 8'h30, 8'd4, 32'h0, 4'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", resp_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    resp_log.delete();
    send(4'hB, 1'b0, 8'h30, 8'd4, 32'h1234, 4'hF);
    drain();
    chk("midrst_log_n", resp_log.size(), 1);
    chk("midrst_sc", resp_log[0], 32'd1);

`ifdef TCDM_LRSC_PERF_EN
    pulse_reset();
    send(4'hA, 1'b0, 8'h70, 8'd1, 32'h0, 4'h0);
    send(4'hB, 1'b0, 8'h70, 8'd1, 32'h11, 4'hF);
    send(4'hA, 1'b0, 8'h71, 8'd2, 32'h0, 4'h0);
    send(4'hB, 1'b0, 8'h71, 8'd2, 32'h22, 4'hF);
    send(4'hB, 1'b0, 8'h72, 8'd3, 32'h33, 4'hF);
    send(4'hB, 1'b0, 8'h70, 8'd1, 32'h44, 4'hF);
    send(4'hB, 1'b0, 8'h73, 8'd2, 32'h55, 4'hF);
    drain();
    @(negedge clk);
    chk("perf_ok", sc_ok_cnt, 16'd2);
    chk("perf_fail", sc_fail_cnt, 16'd3);
    @(posedge clk); #1;
`endif

    // Randomized traffic on a small address/id space to provoke hits
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 7));
      in_valid   = ($urandom_range(0, 3) != 0);
      in_amo     = (r < 3) ? 4'h0 : (r == 3) ? 4'h3 : (r < 6) ? 4'hA : 4'hB;
      in_wen     = $urandom_range(0, 1) != 0;
      in_addr    = 8'h60 + 8'($urandom_range(0, 3));
      in_id      = 8'($urandom_range(0, 3));
      in_wdata   = $urandom;
      in_be      = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tcdm_lrsc_queue.md
# tcdm_lrsc_queue

Bank-side LR/SC reservation unit placed in front of one TCDM bank. It generalises single-reservation LR/SC to `NumEntries` concurrent reservations with round-robin eviction. It resolves SC success or failure locally and suppresses the bank write on failure. Responses return in order through a two-entry response buffer.

## Interface

Parameters:

- `NumEntries`, 1: reservation slots. A value of 1 gives classic LR/SC.
- `AddrWidth`, 8: bank word address width (TCDM bank address).
- `DataWidth`, 32: data width.
- `IdWidth`, 8: initiator id width (meta id, core id and initiator tile, concatenated).

Ports (clock and reset first):

- `clk_i` in 1: clock.
- `rst_i` in 1: one clock; reset is synchronous and active-high.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: request ready.
- `in_addr_i` in AddrWidth: word address.
- `in_wen_i` in 1: write enable.
- `in_amo_i` in 4: operation. `4'h0` plain, `4'hA` LR, `4'hB` SC. All other codes are treated as plain.
- `in_id_i` in IdWidth: initiator id.
- `in_wdata_i` in DataWidth: write data.
- `in_be_i` in DataWidth/8: byte enables.
- `bank_req_o` out 1: bank access this cycle.
- `bank_addr_o` out AddrWidth: bank address.
- `bank_wen_o` out 1: bank write.
- `bank_wdata_o` out DataWidth: bank write data.
- `bank_be_o` out DataWidth/8: bank byte enables.
- `bank_rdata_i` in DataWidth: bank read data. Valid one cycle after `bank_req_o`.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: response ready.
- `resp_data_o` out DataWidth: response data.
- `resp_id_o` out IdWidth: id of the responding request.

## Operation

- A request is accepted when `in_valid_i && in_ready_o`. Every accepted request produces exactly one response, in acceptance order.
- Reservation table: `NumEntries` entries of {valid, id, addr}. Round-robin pointer `rr`, range 0..NumEntries-1.
- **Plain read** (amo 0, wen 0): bank read. Response data is `bank_rdata_i`.
- **Plain write** (amo 0, wen 1): bank write, and every entry with a matching addr is invalidated (any id). Response data is 0.
- **LR**: bank read, then a reservation is recorded. Slot selection, in priority order:
  - the entry already holding the same id (overwritten);
  - otherwise the lowest-index invalid entry;
  - otherwise entry `rr` is evicted and `rr` increments, wrapping to 0.
  - Response data is the read data.
- **SC** (`in_wen_i` is ignored and the operation is treated as a write): success requires a valid entry with matching id and addr.
  - Success: bank write of `in_wdata_i`/`in_be_i`; all entries matching addr are invalidated, including the entry for this id. Response data is 0.
  - Failure: `bank_req_o` stays 0 that cycle; the entry for this id is invalidated if present. Response data is 1.
- The table and `rr` update in the acceptance cycle, so the next request observes the new state.
- Bank outputs are combinational from the accepted request. `bank_req_o = accept && !sc_fail`.

## Timing

- Reset values:
  - `in_ready_o` = 1 (after the reset cycle);
  - `bank_req_o` = 0;
  - `resp_valid_o` = 0;
  - `resp_data_o` and `resp_id_o` = 0;
  - all entries invalid, `rr` = 0, buffer empty, in-flight flag cleared.
- Latency: a request accepted in cycle t has its response visible on `resp_valid_o` in cycle t+1 when the buffer is empty. The buffer is fall-through.
- A response is popped when `resp_valid_o && resp_ready_i`. `resp_data_o` and `resp_id_o` hold stable while `resp_valid_o && !resp_ready_i`.
- Credits: `in_ready_o = (inflight + stored) < 2`. A pop does not free credit in the same cycle, so there is no combinational path from `resp_ready_i` to `in_ready_o`.
- With `resp_ready_i` held at 1, sustained throughput is one request per cycle.
- Buffer full (2 stored): `in_ready_o` = 0 until a pop has occurred in an earlier cycle.
- SC failure still takes the one-cycle slot, which preserves ordering.
- Reset mid-operation: in-flight and buffered responses are discarded and reservations are cleared. No response is emitted for dropped requests.

## Configuration

- `TCDM_LRSC_PERF_EN`:
  - Defined: adds outputs `sc_ok_cnt_o` [15:0] and `sc_fail_cnt_o` [15:0]. Each counter increments on every accepted SC success or failure respectively, saturates at 16'hFFFF, and resets to 0.
  - Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan

- NumEntries=1, bank[0x10]=0xDEAD:
  - LR id 3 @0x10 -> response 0xDEAD, id 3, at t+1.
  - SC id 3 @0x10 data 0x55 -> response 0 and bank[0x10]=0x55.
- LR id 1 @0x20, then plain write id 2 @0x20, then SC id 1 @0x20 -> SC response 1; `bank_req_o` = 0 in the SC cycle; bank[0x20] holds id 2's data.
- NumEntries=2: LR id 1 @A, LR id 2 @B, LR id 3 @C (evicts entry 0, `rr` -> 1) -> SC id 1 @A responds 1; SC id 2 @B responds 0.
- Hold `resp_ready_i` = 0 and present three back-to-back requests -> two accepted, `in_ready_o` = 0 from the third cycle. Release -> responses pop in order; the third request is accepted the cycle after the first pop.
- LR id 4 @0x30, assert `rst_i` for one cycle with a response pending, then SC id 4 @0x30 -> pending response never appears; SC responds 1.
- With `TCDM_LRSC_PERF_EN`: two successful SCs and three failed SCs -> `sc_ok_cnt_o` = 2, `sc_fail_cnt_o` = 3.
